rr_grant_scheduler: RTL and testbench
=====================================

// Module: rr_grant_scheduler
// PURPOSE
//  Round-robin scheduler that shares one downstream resource among NUM_REQ requesters.
//  Sits in front of the shared datapath and issues exactly one registered one-hot grant.
//  The grant is held for a whole transaction, which ends on owner release, done, or a
//  HOLD_MAX timeout. Every ownership change is separated by one bus-turnaround cycle.
// PARAMETERS
//  NUM_REQ   4   number of requesters, 2..16
//  HOLD_MAX  16  max consecutive grant cycles per owner; 0 = unlimited (no timeout)
//  ID_W      2   width of grant_id; must equal clog2(NUM_REQ)
// PORTS
//  clk       in   1        rising-edge clock, single clock domain
//  reset     in   1        asynchronous, active-low reset
//  request   in   NUM_REQ  request[i]=1: requester i wants or holds the resource
//  done      in   1        owner signals end of transaction (sampled only in GRANT)
//  grant     out  NUM_REQ  registered one-hot grant; all zero when no owner
//  grant_id  out  ID_W     index of current owner; holds last owner when grant==0
//  busy      out  1        1 while state==GRANT (equals |grant)
//  timeout   out  1        one-cycle pulse: previous owner was cut off by HOLD_MAX
// BEHAVIOUR
//  Reset (reset=0, asynchronous, takes effect immediately):
//   - grant=0, grant_id=0, busy=0, timeout=0
//   - state=IDLE, ptr=0, hold_cnt=0
//  State machine: IDLE, GRANT, GAP.
//  Search: first i with request[i]=1, scanning ptr, ptr+1, ... wrapping mod NUM_REQ.
//  IDLE:
//   - no request -> stay in IDLE
//   - any request -> at next edge: grant[i]=1, grant_id=i, busy=1, hold_cnt=1, go to GRANT
//   - latency from request to grant = 1 cycle
//  GRANT, evaluated each edge in this priority order:
//   1. request[owner]==0 or done==1 -> release
//   2. HOLD_MAX!=0 and hold_cnt==HOLD_MAX -> release, timeout=1 during the GAP cycle
//   3. otherwise -> hold grant, hold_cnt+1
//  Timeout detail:
//   - owner receives exactly HOLD_MAX grant cycles
//   - done or a dropped request in the final cycle suppresses timeout
//  Release:
//   - grant=0, busy=0, ptr=(owner+1) mod NUM_REQ, go to GAP
//   - the released owner becomes lowest priority
//  GAP:
//   - grant=0 for exactly one cycle; timeout clears at the next edge
//   - search runs on the new ptr: any request -> GRANT next edge, else -> IDLE
//   - the same owner may be re-granted if it is the only requester
//  Other rules:
//   - non-owner request changes during GRANT are ignored; they never preempt
//   - done outside GRANT is ignored
//   - hold_cnt saturates and never wraps; it is sized to hold HOLD_MAX
//   - grant is never multi-hot; grant is never asserted without a matching request
//     in the previous cycle
//   - reset asserted mid-transaction drops grant asynchronously
//   - the first arbitration after reset release starts from ptr=0
// TESTING
//  T1 reset: grant=4'b0010, then reset=0 mid-cycle -> grant=0, busy=0 immediately;
//     after release, request=4'b1111 -> grant=4'b0001 one cycle later
//  T2 rotation: request=4'b1111 held, done pulsed each grant
//     -> grants 0001,0010,0100,1000,0001, each separated by one zero cycle
//  T3 release: owner 2 drops request after 3 grant cycles
//     -> grant=0 next edge, timeout=0; a waiting requester 3 is granted after the gap
//  T4 timeout: HOLD_MAX=16, request=4'b0001 held, done=0
//     -> grant high exactly 16 cycles, then timeout=1 for 1 cycle, grant=0;
//     re-granted on the following edge
//  T5 contention: owner 1 in GRANT, request 4'b0101 appears
//     -> no preemption; after owner 1 releases, grant=4'b0100 (ptr=2) before 4'b0001
//  T6 boundary: done=1 and hold_cnt==HOLD_MAX in the same cycle -> release with timeout=0;
//     done pulsed in IDLE -> no effect

Source files
------------

// File: rtl/rr_grant_scheduler_if.sv
// rtl/rr_grant_scheduler_if.sv - requester/grant bundle between clients and the round-robin scheduler
interface rr_grant_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0] request;
    logic               done;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               busy;
    logic               timeout;

    // master: the requester side; slave: the scheduler
    modport master (
        output request, done,
        input  grant, grant_id, busy, timeout
    );

    modport slave (
        input  request, done,
        output grant, grant_id, busy, timeout
    );
endinterface

// File: rtl/rr_grant_scheduler.sv
// rtl/rr_grant_scheduler.sv - round-robin owner scheduler with hold timeout and one-cycle turnaround gap
module rr_grant_scheduler #(
    parameter int NUM_REQ  = 4,
    parameter int HOLD_MAX = 16,
    parameter int ID_W     = 2
) (
    input  logic               clk,
    input  logic               reset,
    rr_grant_scheduler_if.slave bus
);
    localparam int HC_W = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
    localparam logic [HC_W-1:0] HOLD_LIM = HC_W'(HOLD_MAX);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [HC_W-1:0]    hold_cnt_q, hold_cnt_d;
    logic               timeout_q, timeout_d;

    logic               found;
    logic [ID_W-1:0]    pick;
    logic [ID_W-1:0]    idx_w;
    int                 idx;

    // first requester at or after ptr, wrapping modulo NUM_REQ
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        idx   = 0;
        idx_w = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_w = ID_W'(idx);
            if (!found && bus.request[idx_w]) begin
                found = 1'b1;
                pick  = idx_w;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_id_d = grant_id_q;
        grant_d    = grant_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;

        case (state_q)
            ST_GRANT: begin
                if (!bus.request[grant_id_q] || bus.done ||
                    ((HOLD_MAX != 0) && (hold_cnt_q == HOLD_LIM))) begin
                    // done / dropped request take priority, so they mask the timeout
                    timeout_d = bus.request[grant_id_q] && !bus.done;
                    grant_d   = '0;
                    state_d   = ST_GAP;
                    ptr_d     = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0
                                                                   : grant_id_q + ID_W'(1);
                end else if (hold_cnt_q != '1) begin
                    hold_cnt_d = hold_cnt_q + HC_W'(1);
                end
            end
            default: begin
                if (found) begin
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    grant_id_d    = pick;
                    hold_cnt_d    = HC_W'(1);
                    state_d       = ST_GRANT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            grant_id_q <= '0;
            grant_q    <= '0;
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_id_q <= grant_id_d;
            grant_q    <= grant_d;
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.grant    = grant_q;
    assign bus.grant_id = grant_id_q;
    assign bus.busy     = (state_q == ST_GRANT);
    assign bus.timeout  = timeout_q;
endmodule

// File: tb/tb_rr_grant_scheduler.sv
// tb/tb_rr_grant_scheduler.sv - scoreboard bench for rr_grant_scheduler against a transaction-level model
module tb_rr_grant_scheduler;
    localparam int N  = 4;
    localparam int HM = 16;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rr_grant_scheduler_if #(.NUM_REQ(N), .ID_W(IW)) bus ();

    rr_grant_scheduler #(.NUM_REQ(N), .HOLD_MAX(HM), .ID_W(IW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [N-1:0]  g;
        logic [IW-1:0] id;
        logic          b;
        logic          t;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    // model: owner index (-1 = none), cycles granted so far, rotation pointer
    int   m_owner;
    int   m_cnt;
    int   m_ptr;
    int   m_id;
    bit   m_to;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_cnt   = 0;
        m_ptr   = 0;
        m_id    = 0;
        m_to    = 1'b0;
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic d);
        if (m_owner >= 0) begin
            if (!r[m_owner] || d || (HM != 0 && m_cnt == HM)) begin
                m_to    = r[m_owner] && !d;
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end else begin
                m_cnt++;
            end
        end else begin
            m_to = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (m_owner < 0 && r[(m_ptr + k) % N]) begin
                    m_owner = (m_ptr + k) % N;
                end
            end
            if (m_owner >= 0) begin
                m_cnt = 1;
                m_id  = m_owner;
            end
        end
    endtask

    task automatic drive(input logic [N-1:0] r, input logic d);
        exp_t e;
        @(negedge clk);
        bus.request = r;
        bus.done    = d;
        model_step(r, d);
        e.g  = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        e.id = IW'(m_id);
        e.b  = (m_owner >= 0);
        e.t  = m_to;
        exp_q.push_back(e);
        mon_en = 1'b1;
    endtask

    // monitor: every cycle presents one registered result
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                chk("scoreboard_underflow", 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("grant",    32'(bus.grant),    32'(e.g));
                chk("grant_id", 32'(bus.grant_id), 32'(e.id));
                chk("busy",     32'(bus.busy),     32'(e.b));
                chk("timeout",  32'(bus.timeout),  32'(e.t));
            end
        end
    end

    task automatic async_reset_check();
        @(negedge clk);
        mon_en = 1'b0;
        exp_q.delete();
        #2 reset = 1'b0;
        #1;
        chk("rst_grant",    32'(bus.grant),    32'd0);
        chk("rst_busy",     32'(bus.busy),     32'd0);
        chk("rst_timeout",  32'(bus.timeout),  32'd0);
        chk("rst_grant_id", 32'(bus.grant_id), 32'd0);
        bus.request = '0;
        bus.done    = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [N-1:0] r;
        int           len;
        reset       = 1'b0;
        bus.request = '0;
        bus.done    = 1'b0;
        model_reset();
        #12;
        chk("init_grant",    32'(bus.grant),    32'd0);
        chk("init_grant_id", 32'(bus.grant_id), 32'd0);
        chk("init_busy",     32'(bus.busy),     32'd0);
        chk("init_timeout",  32'(bus.timeout),  32'd0);
        @(negedge clk);
        reset = 1'b1;

        // owner 1 granted, then yanked by a mid-cycle reset; restart from ptr 0
        repeat (3) drive(4'b0010, 1'b0);
        async_reset_check();
        repeat (2) drive(4'b1111, 1'b0);

        // rotation with done held high
        repeat (10) drive(4'b1111, 1'b1);

        // owner drops its request while another waits
        repeat (3) drive(4'b0000, 1'b0);
        repeat (3) drive(4'b1100, 1'b0);
        repeat (4) drive(4'b1000, 1'b0);

        // single requester runs into the hold limit and is re-granted
        repeat (2) drive(4'b0000, 1'b0);
        repeat (40) drive(4'b0001, 1'b0);

        // contention never preempts; released owner goes to lowest priority
        repeat (2) drive(4'b0000, 1'b0);
        repeat (3) drive(4'b0010, 1'b0);
        repeat (3) drive(4'b0111, 1'b0);
        repeat (6) drive(4'b0101, 1'b1);

        // done coinciding with the final hold cycle; done while idle
        repeat (3) drive(4'b0000, 1'b1);
        repeat (16) drive(4'b0001, 1'b0);
        drive(4'b0001, 1'b1);
        repeat (3) drive(4'b0000, 1'b0);

        // randomized stretches with a second asynchronous reset in the middle
        for (int blk = 0; blk < 120; blk++) begin
            r   = N'($urandom_range(0, (1 << N) - 1));
            len = $urandom_range(1, 30);
            for (int c = 0; c < len; c++) begin
                drive(r, ($urandom_range(0, 15) == 0));
            end
            if (blk == 60) begin
                async_reset_check();
            end
        end

        @(posedge clk);
        #3;
        mon_en = 1'b0;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
